// File: rtl/data_memory_arbiter.sv
// Arbitrates the single-port data RAM between the CPU memory stage (priority) and a
// DMA/debug requester, with a starvation counter that forces a one-cycle DMA slot.
module data_memory_arbiter #(
  parameter int ADDR_SIZE    = 18,
  parameter int WORD_SIZE    = 18,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cpu_active,
  input  logic [ADDR_SIZE-1:0] cpu_addr,
  input  logic                 cpu_write_enable,
  input  logic [WORD_SIZE-1:0] cpu_in,
  output logic                 cpu_stall,
  output logic [WORD_SIZE-1:0] cpu_read_data,
  input  logic                 dma_req,
  input  logic [ADDR_SIZE-1:0] dma_addr,
  input  logic                 dma_write_enable,
  input  logic [WORD_SIZE-1:0] dma_wdata,
  output logic                 dma_ack,
  output logic [WORD_SIZE-1:0] dma_rdata,
  output logic                 dma_rvalid,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic                 ram_write_enable,
  output logic [WORD_SIZE-1:0] ram_in,
  input  logic [WORD_SIZE-1:0] ram_out
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       rd_owner_dma_q, rd_owner_dma_d;
  logic       force_dma_s;
  logic       dma_grant_s;
  logic       cpu_grant_s;

  // Grant decision and RAM port mux; all grants are suppressed while reset is high.
  always_comb begin
    force_dma_s      = dma_req && (starve_cnt_q == LIMIT);
    dma_grant_s      = !reset && dma_req && (!cpu_active || force_dma_s);
    cpu_grant_s      = !reset && cpu_active && !dma_grant_s;
    cpu_stall        = cpu_active && dma_grant_s;
    dma_ack          = dma_grant_s;
    ram_addr         = cpu_addr;
    ram_in           = cpu_in;
    ram_write_enable = cpu_grant_s && cpu_write_enable;
    if (dma_grant_s) begin
      ram_addr         = dma_addr;
      ram_in           = dma_wdata;
      ram_write_enable = dma_write_enable;
    end else begin
      ram_addr         = cpu_addr;
      ram_in           = cpu_in;
      ram_write_enable = cpu_grant_s && cpu_write_enable;
    end
  end

  // Starvation counter next state: saturates at the limit, where a forced grant follows.
  always_comb begin
    starve_cnt_d   = 4'd0;
    rd_owner_dma_d = dma_grant_s && !dma_write_enable;
    if (!dma_req || dma_grant_s) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q == LIMIT) begin
      starve_cnt_d = starve_cnt_q;
    end else begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q   <= 4'd0;
      rd_owner_dma_q <= 1'b0;
    end else begin
      starve_cnt_q   <= starve_cnt_d;
      rd_owner_dma_q <= rd_owner_dma_d;
    end
  end

  // Read data comes straight from the RAM's registered output; a reset drops a pending return.
  always_comb begin
    cpu_read_data = ram_out;
    dma_rdata     = ram_out;
    dma_rvalid    = rd_owner_dma_q && !reset;
  end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Shares the single-port synchronous data RAM between the processor's memory-access stage and a DMA/debug requester. The CPU has priority. A starvation counter forces one DMA slot after `STARVE_LIMIT` consecutive denied DMA cycles; during that slot the CPU pipeline is stalled. Sits between the register/memory-read stage (its `memory_addr`/`memory_write_enable`/`memory_in` outputs) and the RAM macro. It also returns DMA read data with the RAM's one-cycle latency.

## Interface

Parameters:
- `ADDR_SIZE`, 18: address width.
- `WORD_SIZE`, 18: data width.
- `STARVE_LIMIT`, 4: consecutive denied DMA cycles before a forced DMA grant (1..15).

Ports:
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `cpu_active`  in  1  CPU issues an access this cycle (operation valid, not no-operation).
- `cpu_addr`  in  ADDR_SIZE  CPU address.
- `cpu_write_enable`  in  1  CPU write.
- `cpu_in`  in  WORD_SIZE  CPU write data.
- `cpu_stall`  out  1  CPU access not performed this cycle; pipeline must hold all inputs.
- `cpu_read_data`  out  WORD_SIZE  RAM output, valid the cycle after a CPU read grant.
- `dma_req`  in  1  DMA access request; held with address/data until acked.
- `dma_addr`  in  ADDR_SIZE  DMA address.
- `dma_write_enable`  in  1  DMA write.
- `dma_wdata`  in  WORD_SIZE  DMA write data.
- `dma_ack`  out  1  DMA access performed this cycle.
- `dma_rdata`  out  WORD_SIZE  DMA read data.
- `dma_rvalid`  out  1  `dma_rdata` valid (one cycle after an acked DMA read).
- `ram_addr`  out  ADDR_SIZE  RAM address.
- `ram_write_enable`  out  1  RAM write strobe.
- `ram_in`  out  WORD_SIZE  RAM write data.
- `ram_out`  in  WORD_SIZE  RAM read data, registered inside RAM (1-cycle latency).

## Operation

- Grant is decided combinationally each cycle from `cpu_active`, `dma_req` and `starve_cnt`. `starve_cnt` is a 4-bit register.
- `force_dma = dma_req && starve_cnt == STARVE_LIMIT`.
- Grant rules:
  - DMA wins if `dma_req && (!cpu_active || force_dma)`.
  - Otherwise the CPU wins if `cpu_active`.
  - Otherwise idle.
- `cpu_stall = cpu_active && dma_grant`. It is high only in a forced slot, since an unforced DMA grant implies `!cpu_active`.
- RAM mux:
  - DMA grant: `ram_addr = dma_addr`, `ram_in = dma_wdata`, `ram_write_enable = dma_write_enable`.
  - Otherwise: CPU signals, with `ram_write_enable = cpu_write_enable && cpu_active`.
- `dma_ack = dma_grant`.
- `starve_cnt` next value:
  - 0 if `!dma_req` or `dma_grant`.
  - `starve_cnt + 1` if `dma_req` is denied. It saturates at `STARVE_LIMIT`, which is unreachable past the limit because a forced grant follows.
- Read return:
  - `rd_owner_dma` register = `dma_grant && !dma_write_enable`.
  - `dma_rvalid` = that register; `dma_rdata = ram_out`.
  - `cpu_read_data = ram_out` unconditionally. The CPU only consumes it the cycle after its own read grant.
- Simultaneous CPU and DMA writes to the same address: the winner writes first and the loser writes in a later slot. The final RAM content is the later write.
- The forced slot lasts exactly one cycle. `starve_cnt` is then 0, so the CPU wins at least the following `STARVE_LIMIT` contested cycles.

## Timing

- Reset values, forced during and after `reset`:
  - `starve_cnt = 0`, `rd_owner_dma = 0`.
  - While `reset` is high, `dma_ack`, `cpu_stall` and `ram_write_enable` are 0.
  - `dma_rvalid` is 0 the cycle after reset.
- `dma_ack`, `cpu_stall` and the RAM port signals are same-cycle combinational. A write takes effect at the posedge ending the grant cycle.
- DMA read latency: ack in cycle N, `dma_rvalid` = 1 in cycle N+1 with data.
- Worst-case DMA wait under continuous CPU traffic: `STARVE_LIMIT` denied cycles, ack in cycle `STARVE_LIMIT` + 1.
- Reset mid-operation: a pending read return is dropped (`dma_rvalid` = 0) and the counter clears. The DMA must re-present any unacked request.
- `dma_req` deasserted before ack: the counter clears and no access occurs.

## Test plan

- DMA alone: RAM[5]=0x2AAAA, `dma_req` read addr 5, `cpu_active`=0. Required: `dma_ack`=1 same cycle, `dma_rvalid`=1 next cycle with `dma_rdata`=0x2AAAA, `cpu_stall` never 1.
- Starvation, STARVE_LIMIT=4: `cpu_active`=1 and `dma_req`=1 continuously. Required: `dma_ack` in cycles 5, 10, 15 (1-based); `cpu_stall`=1 exactly in those cycles; CPU accesses land in the other cycles with the held address.
- Same-address writes: CPU writes 0x00111 and DMA writes 0x00222 to addr 10 in the same cycle, counter 0. Required: CPU wins, DMA acked once the CPU goes idle, final RAM[10]=0x00222.
- Request withdrawal: `dma_req` high for 3 contested cycles, then low for 1, then high under CPU traffic. Required: no ack before 4 more denied cycles; counter restarts at 0.
- Reset mid-read: DMA read acked in cycle N, `reset` high in cycle N+1. Required: `dma_rvalid`=0, `starve_cnt`=0, no RAM write during reset.
- CPU read return: CPU read of addr 3 (RAM[3]=0x1F00F), no DMA. Required: `cpu_read_data`=0x1F00F next cycle, `dma_rvalid`=0.
